adxl345_poll_ctrl: RTL and testbench
====================================

Name: adxl345_poll_ctrl

Overview:
Parametrised successor to the single-shot ADXL345 controller. On reset it verifies the device ID over an external 16-bit SPI master and writes three configuration registers. It then polls NUM_CH axis registers at a fixed sample rate and optionally averages 2^AVG_LOG2 samples per axis. It sits between the SPI master (start/busy/16-bit word handshake) and downstream consumers of packed signed axis data.

Parameters:
NUM_CH, 3, number of axes read (1..3), in the order X, Y, Z.
SAMPLE_DIV, 100000, clk cycles per sample tick (>=2).
AVG_LOG2, 0, averaging depth as log2; 0 disables averaging (range 0..4).
BUSY_TO, 64, cycles allowed for spi_busy to rise after spi_start.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
spi_busy  in  1  SPI master transfer in progress.
spi_rx  in  16  word returned by the last transfer; read byte is in [7:0].
spi_tx  out  16  word to send: [15]=R/W (1=read), [14]=MB (0), [13:8]=addr, [7:0]=data.
spi_start  out  1  one-cycle transfer request.
axis_data  out  16*NUM_CH  packed signed samples; channel k at [16k+15:16k].
data_valid  out  1  one-cycle pulse when axis_data updates.
dev_err  out  1  last DEVID read was not 0xE5.
spi_err  out  1  sticky; busy timeout occurred.
overrun  out  1  sticky; tick arrived while a pending tick was still unserviced.

Behaviour:
- Reset values: all outputs 0; FSM returns to ID_RD; tick counter, accumulators and sample count cleared. Reset mid-transfer abandons the transfer and does not wait for spi_busy to fall.
- Transfer primitive XFER:
  - Drive spi_tx and pulse spi_start for 1 cycle.
  - Wait spi_busy=1. If it does not rise within BUSY_TO cycles, set spi_err and go to ERR.
  - Wait spi_busy=0, then capture spi_rx[7:0] on that cycle.
  - spi_tx stays stable from the spi_start cycle until busy falls.
- ID_RD: XFER read of addr 0x00. If the byte is 0xE5, clear dev_err and go to CFG. Otherwise set dev_err and go to ERR.
- CFG: three sequential XFER writes: 0x2C<=0x0A, 0x31<=0x0B, 0x2D<=0x08. Then go to WAIT_TICK.
- Tick counter: free-running 0..SAMPLE_DIV-1 from reset. Wrap sets the pending flag.
  - Wrap while pending=1: set overrun; pending stays 1 (single-depth).
- WAIT_TICK: on pending=1, clear pending and enter RD with ch=0.
- RD: for each ch, XFER read of 0x32+2ch (low byte), then 0x33+2ch (high byte). Sample = {hi,lo} as signed 16-bit.
- ACC: acc[ch] += sign-extended sample. acc width is 16+AVG_LOG2, so there is no overflow.
  - If ch<NUM_CH-1, increment ch and return to RD.
  - Otherwise increment the sample count.
- When the sample count reaches 2^AVG_LOG2 (OUT state):
  - axis_data[ch] = acc[ch] >>> AVG_LOG2 (arithmetic shift, truncation toward -inf).
  - data_valid pulses on the cycle after the last byte capture.
  - acc and sample count clear.
  - Return to WAIT_TICK.
- With AVG_LOG2=0, every tick produces one data_valid.
- ERR: wait for the next tick wrap (pending consumed), then go to ID_RD. axis_data holds its last value. Accumulators and sample count clear.
- Simultaneous reset and tick: reset wins.
- spi_busy seen high in WAIT_TICK: ignored.

Test Plan:
1. Reset, SPI model returns DEVID 0xE5 -> spi_tx sequence 0x8000, 0x2C0A, 0x310B, 0x2D08, each with a single-cycle spi_start; dev_err=0.
2. NUM_CH=3, AVG_LOG2=0, SAMPLE_DIV=200. Model returns X=0x1234, Y=0xFF9C, Z=0x0100 as byte pairs -> axis_data={0x0100,0xFF9C,0x1234}; data_valid pulses once per 200 cycles; read addresses 0x32..0x37 in order.
3. AVG_LOG2=2. X samples 10, 11, -3, -5 -> one data_valid after the 4th sample; X=0x0003 (13>>>2). A further 4 samples of -1 -> X=0xFFFF.
4. DEVID returns 0xAD -> dev_err=1, no CFG writes, retry at the next tick. Model then returns 0xE5 -> dev_err=0 and CFG proceeds.
5. SPI model never raises spi_busy -> spi_err=1 exactly BUSY_TO cycles after spi_start; stays sticky; ID_RD retried after the next tick.
6. SAMPLE_DIV=20 with a slow SPI model (30-cycle transfers) -> overrun=1. Reset asserted mid-transfer -> all outputs 0 the next cycle; spi_start reissues 0x8000 after release.

Source files
------------

// File: rtl/adxl345_poll_ctrl.sv
// ADXL345 bring-up and polling controller over an external 16-bit SPI master.
// Checks DEVID, writes three config registers, then reads NUM_CH axes per sample tick and averages 2^AVG_LOG2 samples.
// Outputs are registered. data_valid fires the cycle after the final byte of an averaging window is captured.
module adxl345_poll_ctrl #(
    parameter int NUM_CH     = 3,
    parameter int SAMPLE_DIV = 100000,
    parameter int AVG_LOG2   = 0,
    parameter int BUSY_TO    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_busy,
    input  logic [15:0]          spi_rx,
    output logic [15:0]          spi_tx,
    output logic                 spi_start,
    output logic [16*NUM_CH-1:0] axis_data,
    output logic                 data_valid,
    output logic                 dev_err,
    output logic                 spi_err,
    output logic                 overrun
);
    localparam int         AW      = 16 + AVG_LOG2;
    localparam int         TW      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int         BW      = $clog2(BUSY_TO + 1);
    localparam logic [4:0] NAVG    = 5'(1 << AVG_LOG2);
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    typedef enum logic [2:0] {ST_ID_RD, ST_CFG, ST_WAIT_TICK, ST_RD, ST_ERR} state_t;
    // Sub-phases of one SPI transfer: request, wait for busy to rise, wait for busy to fall.
    typedef enum logic [1:0] {PH_ISSUE, PH_BUSY_HI, PH_BUSY_LO} phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic [TW-1:0]         tick_q;
    logic                  tick_wrap;
    logic [1:0]            ch_q, ch_d;
    logic                  hi_q, hi_d;
    logic [1:0]            cfg_q, cfg_d;
    logic [7:0]            lo_q, lo_d;
    logic [BW-1:0]         to_q, to_d;
    logic [4:0]            cnt_q, cnt_d;
    logic signed [AW-1:0]  acc_q [NUM_CH];
    logic signed [AW-1:0]  acc_d [NUM_CH];
    logic [16*NUM_CH-1:0]  axis_q, axis_d;
    logic [15:0]           tx_q, tx_d;
    logic                  start_q, start_d;
    logic                  dv_q, dv_d;
    logic                  dev_err_q, dev_err_d;
    logic                  spi_err_q, spi_err_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;

    logic                  xfer_done;
    logic                  consume;
    logic [15:0]           xfer_word;
    logic [15:0]           cfg_word;
    logic [5:0]            rd_addr;
    logic signed [15:0]    sample;
    logic signed [AW-1:0]  sh;
    logic                  unused_rx;

    // Only the low byte of a transfer result carries register data.
    assign unused_rx  = ^spi_rx[15:8];
    assign tick_wrap  = (tick_q == TW'(SAMPLE_DIV - 1));

    // Free-running sample-rate divider, independent of FSM state.
    always_ff @(posedge clk) begin
        if (reset || tick_wrap) tick_q <= '0;
        else                    tick_q <= tick_q + TW'(1);
    end

    // Next-state, transfer sequencing and accumulate/average datapath.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ch_d      = ch_q;
        hi_d      = hi_q;
        cfg_d     = cfg_q;
        lo_d      = lo_q;
        to_d      = to_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        axis_d    = axis_q;
        tx_d      = tx_q;
        start_d   = 1'b0;
        dv_d      = 1'b0;
        dev_err_d = dev_err_q;
        spi_err_d = spi_err_q;
        xfer_done = 1'b0;
        consume   = 1'b0;
        sample    = '0;
        sh        = '0;
        rd_addr   = 6'h32 + {3'b000, ch_q, hi_q};

        case (cfg_q)
            2'd0:    cfg_word = 16'h2C0A;
            2'd1:    cfg_word = 16'h310B;
            default: cfg_word = 16'h2D08;
        endcase
        xfer_word = 16'h8000;
        if (state_q == ST_CFG)     xfer_word = cfg_word;
        else if (state_q == ST_RD) xfer_word = {2'b10, rd_addr, 8'h00};

        if (state_q == ST_ID_RD || state_q == ST_CFG || state_q == ST_RD) begin
            case (phase_q)
                PH_ISSUE: begin
                    tx_d    = xfer_word;
                    start_d = 1'b1;
                    to_d    = '0;
                    phase_d = PH_BUSY_HI;
                end
                PH_BUSY_HI: begin
                    if (spi_busy) begin
                        phase_d = PH_BUSY_LO;
                    end else if (to_q == BW'(BUSY_TO - 1)) begin
                        spi_err_d = 1'b1;
                        state_d   = ST_ERR;
                        phase_d   = PH_ISSUE;
                    end else begin
                        to_d = to_q + BW'(1);
                    end
                end
                default: begin
                    if (!spi_busy) begin
                        xfer_done = 1'b1;
                        phase_d   = PH_ISSUE;
                    end
                end
            endcase
        end

        case (state_q)
            ST_ID_RD: begin
                if (xfer_done) begin
                    if (spi_rx[7:0] == 8'hE5) begin
                        dev_err_d = 1'b0;
                        cfg_d     = 2'd0;
                        state_d   = ST_CFG;
                    end else begin
                        dev_err_d = 1'b1;
                        state_d   = ST_ERR;
                    end
                end
            end
            ST_CFG: begin
                if (xfer_done) begin
                    if (cfg_q == 2'd2) state_d = ST_WAIT_TICK;
                    else               cfg_d   = cfg_q + 2'd1;
                end
            end
            ST_WAIT_TICK: begin
                if (pend_q) begin
                    consume = 1'b1;
                    ch_d    = 2'd0;
                    hi_d    = 1'b0;
                    phase_d = PH_ISSUE;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (xfer_done) begin
                    if (!hi_q) begin
                        lo_d = spi_rx[7:0];
                        hi_d = 1'b1;
                    end else begin
                        hi_d   = 1'b0;
                        sample = {spi_rx[7:0], lo_q};
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (2'(k) == ch_q) acc_d[k] = acc_q[k] + AW'(sample);
                        end
                        if (ch_q != LAST_CH) begin
                            ch_d = ch_q + 2'd1;
                        end else begin
                            ch_d    = 2'd0;
                            state_d = ST_WAIT_TICK;
                            if (cnt_q + 5'd1 == NAVG) begin
                                // Window complete: publish the floored mean and restart accumulation.
                                for (int k = 0; k < NUM_CH; k++) begin
                                    sh                   = acc_d[k] >>> AVG_LOG2;
                                    axis_d[16*k +: 16]   = sh[15:0];
                                    acc_d[k]             = '0;
                                end
                                dv_d  = 1'b1;
                                cnt_d = 5'd0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                    end
                end
            end
            default: begin
                // ERR: drop stale ticks and partial sums; retry bring-up on the next wrap.
                consume = 1'b1;
                ch_d    = 2'd0;
                hi_d    = 1'b0;
                cnt_d   = 5'd0;
                for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
                if (tick_wrap) begin
                    phase_d = PH_ISSUE;
                    state_d = ST_ID_RD;
                end
            end
        endcase

        pend_d = tick_wrap | (pend_q & ~consume);
        ovr_d  = ovr_q | (tick_wrap & pend_q & ~consume);
        if (state_q == ST_ERR) pend_d = 1'b0;
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ID_RD;
            phase_q   <= PH_ISSUE;
            ch_q      <= '0;
            hi_q      <= 1'b0;
            cfg_q     <= '0;
            lo_q      <= '0;
            to_q      <= '0;
            cnt_q     <= '0;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
            axis_q    <= '0;
            tx_q      <= '0;
            start_q   <= 1'b0;
            dv_q      <= 1'b0;
            dev_err_q <= 1'b0;
            spi_err_q <= 1'b0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ch_q      <= ch_d;
            hi_q      <= hi_d;
            cfg_q     <= cfg_d;
            lo_q      <= lo_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
            axis_q    <= axis_d;
            tx_q      <= tx_d;
            start_q   <= start_d;
            dv_q      <= dv_d;
            dev_err_q <= dev_err_d;
            spi_err_q <= spi_err_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
        end
    end

    assign spi_tx     = tx_q;
    assign spi_start  = start_q;
    assign axis_data  = axis_q;
    assign data_valid = dv_q;
    assign dev_err    = dev_err_q;
    assign spi_err    = spi_err_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_adxl345_poll_ctrl.sv
// Bench for adxl345_poll_ctrl: behavioural SPI slave, transaction logs and an averaging reference model.
// Directed bring-up / error / overrun steps plus random axis samples checked per averaging window.
// Slave answers each spi_start after a programmable busy time, or never when no_busy is set.
`timescale 1ns/1ps
module tb_adxl345_poll_ctrl;
    localparam int NCH  = 3;
    localparam int SDIV = 200;
    localparam int AVG  = 2;
    localparam int BTO  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              spi_busy;
    logic [15:0]       spi_rx;
    logic [15:0]       spi_tx;
    logic              spi_start;
    logic [16*NCH-1:0] axis_data;
    logic              data_valid;
    logic              dev_err;
    logic              spi_err;
    logic              overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          lat = 3;
    bit          no_busy = 1'b0;
    logic [7:0]  devid = 8'hE5;
    logic [47:0] samp_q[$];
    logic [47:0] used_q[$];
    logic [47:0] dv_q[$];
    logic [15:0] tx_log[$];
    int          st_cyc[$];
    int          dv_cyc[$];
    int          dbl_start = 0;

    adxl345_poll_ctrl #(
        .NUM_CH(NCH), .SAMPLE_DIV(SDIV), .AVG_LOG2(AVG), .BUSY_TO(BTO)
    ) dut (
        .clk(clk), .reset(reset), .spi_busy(spi_busy), .spi_rx(spi_rx),
        .spi_tx(spi_tx), .spi_start(spi_start), .axis_data(axis_data),
        .data_valid(data_valid), .dev_err(dev_err), .spi_err(spi_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SPI slave: register map with DEVID at 0x00 and axis bytes at 0x32..0x37.
    initial begin : spi_slave
        int          left;
        int          idx;
        logic [15:0] resp;
        logic [47:0] cur;
        left = 0; idx = 0; resp = '0; cur = '0;
        spi_busy = 1'b0; spi_rx = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                spi_busy = 1'b0; left = 0;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin spi_busy = 1'b0; spi_rx = resp; end
            end else if (spi_start && !no_busy) begin
                resp = 16'h0;
                if (spi_tx[15]) begin
                    if (spi_tx[13:8] == 6'h00) begin
                        resp = {8'h00, devid};
                    end else if (spi_tx[13:8] >= 6'h32 && spi_tx[13:8] <= 6'h37) begin
                        if (spi_tx[13:8] == 6'h32) begin
                            cur = (samp_q.size() > 0) ? samp_q.pop_front() : 48'h0;
                            used_q.push_back(cur);
                        end
                        idx  = int'(spi_tx[13:8]) - 'h32;
                        resp = {8'h00, cur[8*idx +: 8]};
                    end
                end
                spi_busy = 1'b1; left = lat;
            end
        end
    end

    // Transfer and output-sample logs.
    initial begin : monitor
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && spi_start) begin
                tx_log.push_back(spi_tx); st_cyc.push_back(cyc);
                if (prev_start) dbl_start++;
            end
            if (!reset && data_valid) begin
                dv_q.push_back(axis_data); dv_cyc.push_back(cyc);
            end
            prev_start = spi_start;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tx_at(input int i);
        return (tx_log.size() > i) ? tx_log[i] : 16'hxxxx;
    endfunction

    function automatic logic [47:0] dv_at(input int i);
        return (dv_q.size() > i) ? dv_q[i] : 48'hx;
    endfunction

    // Floored mean of each axis over the g-th window of four consumed samples.
    function automatic logic [47:0] exp_avg(input int g);
        logic [47:0]        r;
        logic [47:0]        t;
        logic signed [15:0] v;
        int                 s;
        int                 q;
        r = 'x;
        if (used_q.size() < 4*g + 4) return r;
        for (int ax = 0; ax < NCH; ax++) begin
            s = 0;
            for (int i = 0; i < 4; i++) begin
                t = used_q[4*g + i];
                v = t[16*ax +: 16];
                s += int'(v);
            end
            q = s / 4;
            if ((s % 4) != 0 && s < 0) q -= 1;
            r[16*ax +: 16] = q[15:0];
        end
        return r;
    endfunction

    task automatic wait_tx(input int n, input int budget, input string tag);
        int t = 0;
        while (tx_log.size() < n && t < budget) begin @(negedge clk); t++; end
        chk(tag, 64'(tx_log.size() >= n), 64'd1);
    endtask

    task automatic wait_dv(input int n, input int budget, input string tag);
        int t = 0;
        while (dv_q.size() < n && t < budget) begin @(negedge clk); t++; end
        chk(tag, 64'(dv_q.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        tx_log.delete(); st_cyc.delete(); dv_q.delete(); dv_cyc.delete(); used_q.delete();
        dbl_start = 0;
        @(negedge clk);
        reset = 1'b0; rel_cyc = cyc;
    endtask

    initial begin : main
        int t;
        int d;
        reset = 1'b1;
        samp_q.push_back({16'($urandom()), 16'($urandom()), 16'd10});
        samp_q.push_back({16'($urandom()), 16'($urandom()), 16'd11});
        samp_q.push_back({16'($urandom()), 16'($urandom()), 16'hFFFD});
        samp_q.push_back({16'($urandom()), 16'($urandom()), 16'hFFFB});
        repeat (4) samp_q.push_back({16'($urandom()), 16'($urandom()), 16'hFFFF});
        repeat (8) samp_q.push_back({16'($urandom()), 16'($urandom()), 16'($urandom())});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(spi_tx), 64'h0);
        chk("rst_axis", 64'(axis_data), 64'h0);
        chk("rst_flags", 64'({spi_start, data_valid, dev_err, spi_err, overrun}), 64'h0);
        reset = 1'b0; rel_cyc = cyc;

        // Bring-up sequence
        wait_tx(4, 300, "cfg_wait");
        chk("cfg_id",  64'(tx_at(0)), 64'h8000);
        chk("cfg_2c",  64'(tx_at(1)), 64'h2C0A);
        chk("cfg_31",  64'(tx_at(2)), 64'h310B);
        chk("cfg_2d",  64'(tx_at(3)), 64'h2D08);
        chk("cfg_dev_err", 64'(dev_err), 64'h0);

        // Averaged polling
        wait_dv(4, 4*4*SDIV + 500, "dv_wait");
        for (int i = 0; i < 6; i++) begin
            logic [15:0] e;
            e = 16'hB200 + 16'(i << 8);
            chk("rd_addr", 64'(tx_at(4 + i)), 64'(e));
        end
        chk("rd_addr_next", 64'(tx_at(10)), 64'hB200);
        chk("avg_x_13", 64'(dv_at(0) & 48'hFFFF), 64'h0003);
        chk("avg_x_m1", 64'(dv_at(1) & 48'hFFFF), 64'hFFFF);
        for (int g = 0; g < 4; g++) chk("avg_grp", 64'(dv_at(g)), 64'(exp_avg(g)));
        if (dv_cyc.size() >= 4) begin
            chk("dv_period_a", 64'(dv_cyc[2] - dv_cyc[1]), 64'(4*SDIV));
            chk("dv_period_b", 64'(dv_cyc[3] - dv_cyc[2]), 64'(4*SDIV));
        end
        chk("start_single_cycle", 64'(dbl_start), 64'h0);
        chk("no_overrun", 64'(overrun), 64'h0);

        // Wrong DEVID, then recovery
        devid = 8'hAD;
        do_reset();
        wait_tx(1, 20, "badid_wait");
        repeat (20) @(negedge clk);
        chk("badid_dev_err", 64'(dev_err), 64'h1);
        chk("badid_no_cfg", 64'(tx_log.size()), 64'd1);
        devid = 8'hE5;
        wait_tx(2, SDIV + 50, "badid_retry_wait");
        chk("badid_retry_word", 64'(tx_at(1)), 64'h8000);
        d = (st_cyc.size() > 1) ? st_cyc[1] - rel_cyc : -1;
        chk("badid_retry_win", 64'(d >= SDIV && d <= SDIV + 4), 64'd1);
        wait_tx(5, 100, "badid_cfg_wait");
        chk("badid_cfg_2c", 64'(tx_at(2)), 64'h2C0A);
        chk("badid_cfg_2d", 64'(tx_at(4)), 64'h2D08);
        chk("badid_dev_err_clr", 64'(dev_err), 64'h0);

        // Busy never rises
        no_busy = 1'b1;
        do_reset();
        wait_tx(1, 10, "to_wait_start");
        t = 0;
        while (!spi_err && t < BTO + 20) begin @(negedge clk); t++; end
        chk("to_cycles", 64'((st_cyc.size() > 0) ? cyc - st_cyc[0] : -1), 64'(BTO));
        chk("to_spi_err", 64'(spi_err), 64'h1);
        chk("to_dev_err", 64'(dev_err), 64'h0);
        no_busy = 1'b0;
        wait_tx(5, SDIV + 100, "to_retry_wait");
        chk("to_retry_word", 64'(tx_at(1)), 64'h8000);
        chk("to_retry_cfg", 64'(tx_at(2)), 64'h2C0A);
        chk("to_sticky", 64'(spi_err), 64'h1);

        // Slow SPI causes overrun; reset mid-transfer
        lat = 60;
        do_reset();
        t = 0;
        while (!overrun && t < 3000) begin @(negedge clk); t++; end
        chk("ovr_set", 64'(overrun), 64'h1);
        t = 0;
        while (!spi_busy && t < 200) begin @(negedge clk); t++; end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 64'(spi_tx), 64'h0);
        chk("mid_rst_axis", 64'(axis_data), 64'h0);
        chk("mid_rst_flags", 64'({spi_start, data_valid, dev_err, spi_err, overrun}), 64'h0);
        @(negedge clk);
        tx_log.delete(); st_cyc.delete();
        reset = 1'b0; rel_cyc = cyc;
        wait_tx(1, 10, "mid_rst_restart_wait");
        chk("mid_rst_restart_word", 64'(tx_at(0)), 64'h8000);
        chk("mid_rst_restart_cyc", 64'((st_cyc.size() > 0) ? st_cyc[0] - rel_cyc : -1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
